// File: rtl/demux1_2_8bit_buffered.sv
// demux1_2_8bit_buffered: steers valid/ready words into one of two per-channel FIFOs.
//   Ports: clk, rst (async, active-high); in/in_valid/s -> in_ready;
//   out1/out1_valid <- out1_ready, out2/out2_valid <- out2_ready; count1/count2 occupancy.
module demux1_2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_N = (PW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic pop;
  // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1 -> 0.
  assign valid = count != '0;
  assign full  = count == FULL_N;
  assign pop   = valid & rd_ready;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop) count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end
endmodule

module demux1_2_8bit_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  input  logic                   s,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out1,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out2,
  output logic                   out2_valid,
  input  logic                   out2_ready,
  output logic [$clog2(DEPTH):0] count1,
  output logic [$clog2(DEPTH):0] count2
);
  logic full1, full2, push;
  // A full channel refuses the word even if it pops this cycle.
  assign in_ready = s ? ~full1 : ~full2;
  assign push     = in_valid & in_ready;
  demux1_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
    .clk(clk), .rst(rst), .push(push & s), .din(in), .rd_ready(out1_ready),
    .dout(out1), .valid(out1_valid), .full(full1), .count(count1)
  );
  demux1_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch2 (
    .clk(clk), .rst(rst), .push(push & ~s), .din(in), .rd_ready(out2_ready),
    .dout(out2), .valid(out2_valid), .full(full2), .count(count2)
  );
endmodule

// File: tb/tb_demux1_2_8bit_buffered.sv
// tb_demux1_2_8bit_buffered: directed and scoreboarded checks of the buffered 1:2 demux.
module tb_demux1_2_8bit_buffered;
  logic clk = 0, rst = 1;
  logic [7:0] in = '0;
  logic in_valid = 0, s = 0, out1_ready = 0, out2_ready = 0;
  logic in_ready, out1_valid, out2_valid;
  logic [7:0] out1, out2;
  logic [1:0] count1, count2;
  int n_checks = 0, n_pass = 0;
  logic [7:0] q1[$], q2[$];
  logic [7:0] exp_w;
  always #5 clk = ~clk;
  demux1_2_8bit_buffered dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .s(s), .in_ready(in_ready),
    .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2(out2), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .count1(count1), .count2(count2)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    check("rst_v1", out1_valid, 0);
    check("rst_v2", out2_valid, 0);
    check("rst_o1", out1, 0);
    check("rst_o2", out2, 0);
    check("rst_c1", count1, 0);
    check("rst_c2", count2, 0);
    check("rst_rdy", in_ready, 1);
    rst = 0;
    tick();
    in = 8'hA5; s = 1; in_valid = 1;
    tick();
    check("rt_o1", out1, 8'hA5);
    check("rt_v1", out1_valid, 1);
    check("rt_v2_empty", out2_valid, 0);
    in = 8'h3C; s = 0;
    tick();
    in_valid = 0;
    check("rt_o2", out2, 8'h3C);
    check("rt_v2", out2_valid, 1);
    check("rt_c1", count1, 1);
    check("rt_c2", count2, 1);
    out1_ready = 1; out2_ready = 1;
    tick();
    out1_ready = 0; out2_ready = 0;
    check("drain_c1", count1, 0);
    check("drain_c2", count2, 0);
    check("drain_v1", out1_valid, 0);
    in_valid = 1; s = 1; in = 8'h01;
    tick();
    in = 8'h02;
    tick();
    in_valid = 0;
    #1;
    check("full_c1", count1, 2);
    check("full_rdy1", in_ready, 0);
    s = 0;
    #1;
    check("full_rdy2", in_ready, 1);
    s = 1;
    check("full_o1", out1, 8'h01);
    out1_ready = 1;
    tick();
    out1_ready = 0;
    check("pop_o1", out1, 8'h02);
    check("pop_c1", count1, 1);
    check("pop_rdy1", in_ready, 1);
    in_valid = 1; in = 8'h03;
    tick();
    in = 8'h04; out1_ready = 1;
    #1;
    check("fp_c1", count1, 2);
    check("fp_rdy", in_ready, 0);
    tick();
    in_valid = 0; out1_ready = 0;
    check("fp_c1_after", count1, 1);
    check("fp_o1", out1, 8'h03);
    out1_ready = 1;
    tick();
    out1_ready = 0;
    check("fp_no_push_c1", count1, 0);
    check("fp_no_push_v1", out1_valid, 0);
    in_valid = 1; s = 1; in = 8'h11;
    tick();
    in = 8'h22;
    tick();
    in_valid = 0;
    check("mid_c1", count1, 2);
    rst = 1;
    #1;
    check("arst_v1", out1_valid, 0);
    check("arst_o1", out1, 0);
    check("arst_c1", count1, 0);
    tick();
    rst = 0;
    s = 1;
    #1;
    check("arst_rdy", in_ready, 1);
    out1_ready = 1; in_valid = 1; s = 1;
    for (int i = 0; i < 10; i++) begin
      in = 8'(i);
      tick();
      check("str_o1", out1, i);
      check("str_v1", out1_valid, 1);
      check("str_c1", count1, 1);
    end
    in_valid = 0;
    tick();
    out1_ready = 0;
    check("str_end_c1", count1, 0);
    for (int c = 0; c < 200; c++) begin
      in_valid = 1'($urandom);
      s = 1'($urandom);
      in = 8'($urandom);
      out1_ready = 1'($urandom);
      out2_ready = 1'($urandom);
      #1;
      if (out1_valid && out1_ready) begin
        exp_w = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
        check("sb_o1", out1, exp_w);
      end
      if (out2_valid && out2_ready) begin
        exp_w = (q2.size() > 0) ? q2.pop_front() : 8'hxx;
        check("sb_o2", out2, exp_w);
      end
      if (in_valid && in_ready) begin
        if (s) q1.push_back(in);
        else q2.push_back(in);
      end
      tick();
      check("sb_c1", count1, q1.size());
      check("sb_c2", count2, q2.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/demux1_2_8bit_buffered.md
Name: demux1_2_8bit_buffered

Overview:
- 1-to-2 steering block for 8-bit datapath words: the write-side counterpart of the 2:1 word selector.
- Accepts one word per cycle on a valid/ready input and routes it to output channel 1 or channel 2 by a per-word select.
- Each output channel has its own small FIFO so one stalled consumer does not block words bound for the other channel.
- Sits between a single producer and two downstream consumers in the datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 2, entries per output-channel FIFO. Legal values are 2 or 4. Pointer width is log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  input data word.
- in_valid  input  1  producer has a word on `in`.
- s  input  1  route select, sampled with the word: 1 routes to channel 1, 0 routes to channel 2.
- in_ready  output  1  block can accept the word on the selected channel this cycle.
- out1  output  WIDTH  head word of the channel-1 FIFO.
- out1_valid  output  1  channel-1 FIFO is not empty.
- out1_ready  input  1  channel-1 consumer takes the head word.
- out2  output  WIDTH  head word of the channel-2 FIFO.
- out2_valid  output  1  channel-2 FIFO is not empty.
- out2_ready  input  1  channel-2 consumer takes the head word.
- count1  output  log2(DEPTH)+1  channel-1 occupancy.
- count2  output  log2(DEPTH)+1  channel-2 occupancy.

Behaviour:
- Reset (asynchronous, rst=1):
  - All pointers and counts clear to 0.
  - All storage clears to 0.
  - out1_valid=0, out2_valid=0, out1=0, out2=0, count1=0, count2=0.
  - in_ready follows its combinational rule, so it reads 1 once the FIFOs are empty.
  - Reset asserted mid-operation discards all buffered words. No partial state survives.
- in_ready is combinational:
  - When s=1, in_ready = (count1 != DEPTH).
  - When s=0, in_ready = (count2 != DEPTH).
  - in_ready does not depend on in_valid.
- Push: on a rising edge with in_valid & in_ready, `in` is written at the selected channel's write pointer. That write pointer increments, wrapping from DEPTH-1 to 0.
- Pop: on a rising edge with outN_valid & outN_ready, channel N's read pointer increments with the same wrap. outN_ready while outN_valid=0 is ignored.
- Output latency:
  - outN and outN_valid are driven from storage and counters, with no combinational path from `in` to outN.
  - A word pushed at edge k appears on outN after edge k, when the channel was empty. Minimum latency is 1 cycle.
- Counts:
  - countN goes +1 on push only, -1 on pop only, and is unchanged on push and pop in the same cycle.
  - countN never exceeds DEPTH and never underflows.
- Full channel:
  - A pop in the same cycle does not free the slot early: in_ready stays 0 while countN==DEPTH.
  - The producer holds `in`, `s` and in_valid until in_ready=1.
- Empty channel: outN holds the last value at the read pointer (0 after reset). Consumers qualify outN with outN_valid.
- Simultaneous events:
  - Push to channel 1 with pop from channel 2, or any combination, is independent per channel.
  - Push and pop on the same non-full channel both complete.
- Ordering: words are delivered in FIFO order within a channel. There is no ordering guarantee across channels.
- s is don't-care when in_valid=0.

Test Plan:
- Reset: rst=1 mid-stream with count1=2 -> immediately out1_valid=0, out1=0, count1=0. After release, s=1 gives in_ready=1.
- Routing and latency: with out1_ready=out2_ready=0, push 8'hA5 with s=1, then 8'h3C with s=0.
  - out1=A5 and out1_valid=1 one cycle after its push.
  - out2=3C and out2_valid=1 one cycle after its push.
  - count1=1, count2=1.
- Full/backpressure: push 8'h01 and 8'h02 with s=1 (DEPTH=2).
  - Required: count1=2 and in_ready=0 for s=1, while in_ready=1 for s=0.
  - Then pulse out1_ready for one cycle: out1 goes 01->02, count1=1, in_ready=1 for s=1.
- Full with simultaneous pop: count1=2, out1_ready=1, in_valid=1, s=1 -> no push that cycle (in_ready=0), count1 becomes 1.
- Streaming and wrap-around: out1_ready=1 held, push 10 words 8'h00..8'h09 with s=1 back-to-back.
  - Required: out1 emits 00..09 in order with no loss.
  - count1 stays ≤1.
  - Pointers wrap correctly.
- Concurrent channels: interleave s=1/s=0 pushes while toggling out1_ready/out2_ready randomly for 200 cycles -> scoreboard sees per-channel order preserved and countN matches pushes minus pops.
